multicycle_control: RTL

Multi-cycle main controller for the RV32I core. It sequences the shared ALU, register file, PC and unified instruction/data memory through fetch, decode, execute, memory and writeback. It drives the 2-bit ALUOp consumed by the ALU control decoder, and all mux selects and write enables. It also handles a wait-state handshake with memory.

---
 rtl/multicycle_control_pkg.sv | 34 +++
 rtl/multicycle_control.sv | 123 ++++++++++++
 2 files changed

// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcodes and select encodings for the multicycle controller
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_ALU_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multi-cycle main controller with memory wait-state handshake
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal
);

  state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    ALUOp         = ALUOP_ADD;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        // request stays up across wait states; IR/PC load only in the ready cycle
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_BOFF;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = ST_MEM_ADDR;
          OP_RTYPE:          state_next = ST_EXEC_R;
          OP_ITYPE:          state_next = ST_EXEC_I;
          OP_BRANCH:         state_next = ST_BRANCH;
          default:           state_next = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_EXEC_R: begin
        alu_src_a  = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        state_next = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOp         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
        state_next    = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
